// File: rtl/riu2_histogram.sv
`default_nettype none
//============================================================================
// Module      : riu2_histogram
// Description : Per-frame 10-bin histogram of riu2 codes. Codes qualified by
//               done_i are counted in ACCUM. On progress_done_i the bins are
//               drained serially over a valid/ready port, and each bin is
//               cleared as it is read.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk             : system clock, rising edge
//   rst             : asynchronous active-low reset
//   done_i          : data_i valid this cycle
//   data_i          : riu2 code (0..NUM_BINS-1 valid)
//   progress_done_i : one-cycle frame-end pulse
//   hist_ready_i    : downstream accepts the current bin
//   hist_valid_o    : hist_bin_o / hist_count_o valid
//   hist_bin_o      : bin index being output
//   hist_count_o    : count of that bin
//   frame_done_o    : one-cycle pulse after the last bin is accepted
//   busy_o          : high while draining
//   sat_o           : sticky, some bin saturated this frame
//   lost_o          : sticky, a code or frame-end pulse was dropped
//============================================================================
module riu2_histogram #(
    parameter int NUM_BINS   = 10,
    parameter int CODE_WIDTH = 4,
    parameter int BIN_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done_i,
    input  logic [CODE_WIDTH-1:0] data_i,
    input  logic                  progress_done_i,
    input  logic                  hist_ready_i,
    output logic                  hist_valid_o,
    output logic [CODE_WIDTH-1:0] hist_bin_o,
    output logic [BIN_WIDTH-1:0]  hist_count_o,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output logic                  sat_o,
    output logic                  lost_o
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam logic [BIN_WIDTH-1:0]  BIN_MAX     = '1;
    localparam logic [CODE_WIDTH:0]   NUM_BINS_C  = (CODE_WIDTH+1)'(NUM_BINS);
    localparam logic [CODE_WIDTH-1:0] LAST_BIN    = CODE_WIDTH'(NUM_BINS - 1);

    state_e                  state_q;
    logic [CODE_WIDTH-1:0]   k_q;
    logic                    hist_valid_q;
    logic [BIN_WIDTH-1:0]    hist_count_q;
    logic                    frame_done_q;
    logic                    sat_q;
    logic                    lost_q;
    logic [BIN_WIDTH-1:0]    bin_q [NUM_BINS];

    logic [BIN_WIDTH-1:0]    bin_d [NUM_BINS];
    logic [BIN_WIDTH-1:0]    next_count_d;
    logic [CODE_WIDTH-1:0]   k_inc_d;
    logic                    code_ok_d;
    logic                    count_en_d;
    logic                    sat_set_d;
    logic                    lost_set_d;

    assign code_ok_d  = ({1'b0, data_i} < NUM_BINS_C);
    assign count_en_d = done_i && (state_q == ACCUM) && code_ok_d;
    assign k_inc_d    = k_q + 1'b1;

    // Anything arriving while draining is dropped, as is an out-of-range code.
    assign lost_set_d = (done_i && ((state_q == DRAIN) || !code_ok_d)) ||
                        (progress_done_i && (state_q == DRAIN));

    // Incremented bin values; a full bin holds and flags saturation.
    always_comb begin
        sat_set_d = 1'b0;
        for (int i = 0; i < NUM_BINS; i++) begin
            bin_d[i] = bin_q[i];
            if (count_en_d && (data_i == CODE_WIDTH'(i))) begin
                if (bin_q[i] == BIN_MAX) begin
                    sat_set_d = 1'b1;
                end else begin
                    bin_d[i] = bin_q[i] + 1'b1;
                end
            end
        end
    end

    // Count of the bin presented after the current beat transfers.
    always_comb begin
        next_count_d = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (k_inc_d == CODE_WIDTH'(i)) begin
                next_count_d = bin_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ACCUM;
            k_q          <= '0;
            hist_valid_q <= 1'b0;
            hist_count_q <= '0;
            frame_done_q <= 1'b0;
            sat_q        <= 1'b0;
            lost_q       <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                bin_q[i] <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            // Flags clear after the frame_done pulse, but a new set wins.
            sat_q  <= sat_set_d  || (sat_q  && !frame_done_q);
            lost_q <= lost_set_d || (lost_q && !frame_done_q);

            case (state_q)
                ACCUM: begin
                    for (int i = 0; i < NUM_BINS; i++) begin
                        bin_q[i] <= bin_d[i];
                    end
                    if (progress_done_i) begin
                        state_q      <= DRAIN;
                        k_q          <= '0;
                        hist_valid_q <= 1'b1;
                        // Use bin_d so a coincident code 0 is included.
                        hist_count_q <= bin_d[0];
                    end
                end
                DRAIN: begin
                    // hist_valid_q is always high in DRAIN, so ready alone
                    // marks a transfer.
                    if (hist_ready_i) begin
                        for (int i = 0; i < NUM_BINS; i++) begin
                            if (k_q == CODE_WIDTH'(i)) begin
                                bin_q[i] <= '0;
                            end
                        end
                        if (k_q == LAST_BIN) begin
                            state_q      <= ACCUM;
                            k_q          <= '0;
                            hist_valid_q <= 1'b0;
                            hist_count_q <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            k_q          <= k_inc_d;
                            hist_count_q <= next_count_d;
                        end
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign hist_valid_o = hist_valid_q;
    assign hist_bin_o   = k_q;
    assign hist_count_o = hist_count_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = (state_q == DRAIN);
    assign sat_o        = sat_q;
    assign lost_o       = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_riu2_histogram.sv
`default_nettype none
//============================================================================
// Module      : tb_riu2_histogram
// Description : Directed self-checking bench for riu2_histogram, built with
//               4-bit bins so saturation is reachable in a short frame.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
module tb_riu2_histogram;

    localparam int NUM_BINS   = 10;
    localparam int CODE_WIDTH = 4;
    localparam int BIN_WIDTH  = 4;

    logic                  clk;
    logic                  rst;
    logic                  done_i;
    logic [CODE_WIDTH-1:0] data_i;
    logic                  progress_done_i;
    logic                  hist_ready_i;
    logic                  hist_valid_o;
    logic [CODE_WIDTH-1:0] hist_bin_o;
    logic [BIN_WIDTH-1:0]  hist_count_o;
    logic                  frame_done_o;
    logic                  busy_o;
    logic                  sat_o;
    logic                  lost_o;

    int n_checks = 0;
    int n_pass   = 0;

    riu2_histogram #(
        .NUM_BINS   (NUM_BINS),
        .CODE_WIDTH (CODE_WIDTH),
        .BIN_WIDTH  (BIN_WIDTH)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .done_i          (done_i),
        .data_i          (data_i),
        .progress_done_i (progress_done_i),
        .hist_ready_i    (hist_ready_i),
        .hist_valid_o    (hist_valid_o),
        .hist_bin_o      (hist_bin_o),
        .hist_count_o    (hist_count_o),
        .frame_done_o    (frame_done_o),
        .busy_o          (busy_o),
        .sat_o           (sat_o),
        .lost_o          (lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input int c);
        done_i = 1'b1;
        data_i = CODE_WIDTH'(c);
        tick();
        done_i = 1'b0;
        data_i = '0;
    endtask

    task automatic frame_end();
        progress_done_i = 1'b1;
        tick();
        progress_done_i = 1'b0;
    endtask

    // All outputs packed together for the reset checks.
    function automatic logic [31:0] out_vec();
        return 32'({hist_valid_o, hist_bin_o, hist_count_o, frame_done_o, busy_o, sat_o, lost_o});
    endfunction

    // Drains one frame, checking every beat in order. pat[cyc%4] drives ready.
    // Any done_i/progress_done_i set by the caller is removed after the
    // first drain cycle.
    task automatic drain_check(input string tag, input int exp_cnt [NUM_BINS],
                               input logic [3:0] pat, input logic exp_sat,
                               input logic exp_lost);
        int k = 0;
        int cyc = 0;
        while (k < NUM_BINS && cyc < 200) begin
            hist_ready_i = pat[cyc % 4];
            check({tag, "_valid"}, 32'(hist_valid_o), 32'd1);
            check({tag, "_busy"},  32'(busy_o), 32'd1);
            check({tag, "_bin"},   32'(hist_bin_o), 32'(k));
            check({tag, "_count"}, 32'(hist_count_o), 32'(exp_cnt[k]));
            if (hist_ready_i) k++;
            tick();
            done_i          = 1'b0;
            progress_done_i = 1'b0;
            cyc++;
        end
        hist_ready_i = 1'b0;
        if (k < NUM_BINS) check({tag, "_drain_timeout"}, 32'(k), 32'(NUM_BINS));
        check({tag, "_fdone"},     32'(frame_done_o), 32'd1);
        check({tag, "_busy_end"},  32'(busy_o), 32'd0);
        check({tag, "_valid_end"}, 32'(hist_valid_o), 32'd0);
        check({tag, "_sat"},       32'(sat_o), 32'(exp_sat));
        check({tag, "_lost"},      32'(lost_o), 32'(exp_lost));
        tick();
        check({tag, "_fdone_1cyc"}, 32'(frame_done_o), 32'd0);
        check({tag, "_sat_clr"},    32'(sat_o), 32'd0);
        check({tag, "_lost_clr"},   32'(lost_o), 32'd0);
    endtask

    initial begin
        int exp_cnt [NUM_BINS];
        int fd_seen;

        rst             = 1'b0;
        done_i          = 1'b0;
        data_i          = '0;
        progress_done_i = 1'b0;
        hist_ready_i    = 1'b0;

        // Reset held with random inputs: outputs stay zero.
        for (int i = 0; i < 4; i++) begin
            done_i          = 1'($urandom);
            data_i          = CODE_WIDTH'($urandom);
            progress_done_i = 1'($urandom);
            hist_ready_i    = 1'($urandom);
            tick();
            check("reset_outputs", out_vec(), 32'd0);
        end
        done_i = 1'b0; data_i = '0; progress_done_i = 1'b0; hist_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        check("post_reset_busy", 32'(busy_o), 32'd0);
        check("post_reset_outputs", out_vec(), 32'd0);

        // Basic frame, ready held high.
        send_code(0); send_code(1); send_code(1);
        send_code(9); send_code(9); send_code(9); send_code(5);
        frame_end();
        exp_cnt = '{1, 2, 0, 0, 0, 1, 0, 0, 0, 3};
        drain_check("basic", exp_cnt, 4'b1111, 1'b0, 1'b0);

        // Empty frame drains zeros.
        frame_end();
        exp_cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drain_check("empty", exp_cnt, 4'b1111, 1'b0, 1'b0);

        // Backpressure, ready pattern 1,0,0,1.
        send_code(2); send_code(2); send_code(4); send_code(8); send_code(0);
        frame_end();
        exp_cnt = '{1, 0, 2, 0, 1, 0, 0, 0, 1, 0};
        drain_check("bp", exp_cnt, 4'b1001, 1'b0, 1'b0);

        // Saturation with 4-bit bins: 20 codes of 3 -> 15.
        for (int i = 0; i < 20; i++) send_code(3);
        check("sat_set", 32'(sat_o), 32'd1);
        frame_end();
        exp_cnt = '{0, 0, 0, 15, 0, 0, 0, 0, 0, 0};
        drain_check("sat", exp_cnt, 4'b1111, 1'b1, 1'b0);

        // Out-of-range code, coincident code 7, drops during drain.
        send_code(7);
        send_code(12);
        check("lost_code12", 32'(lost_o), 32'd1);
        done_i = 1'b1; data_i = 4'd7;
        frame_end();
        done_i = 1'b0;
        check("busy_rise", 32'(busy_o), 32'd1);
        done_i = 1'b1; data_i = 4'd2;
        progress_done_i = 1'b1;
        exp_cnt = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
        drain_check("drop", exp_cnt, 4'b1111, 1'b0, 1'b1);
        frame_end();
        exp_cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drain_check("after_drop", exp_cnt, 4'b1111, 1'b0, 1'b0);

        // Reset after bin 4 is accepted.
        send_code(4); send_code(4); send_code(6);
        frame_end();
        hist_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        hist_ready_i = 1'b0;
        check("mid_bin", 32'(hist_bin_o), 32'd5);
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", out_vec(), 32'd0);
        fd_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (frame_done_o) fd_seen++;
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (frame_done_o) fd_seen++;
        end
        check("mid_reset_no_fdone", 32'(fd_seen), 32'd0);
        send_code(1);
        frame_end();
        exp_cnt = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        drain_check("post_abort", exp_cnt, 4'b1111, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
